// File: rtl/chess_ui_pkg.sv
// Shared types and constants for the front-panel cursor/selection block.
//  ui_state_t   : selection state machine encoding (IDLE, SELECTED, COMMIT)
//  SQ_W         : width of a square index {row[2:0],col[2:0]}
//  ROW_MAX/COL_MAX : saturation limits for cursor movement
//  BTN_*        : bit positions of each button in the 7-wide event vector
//  sat_step     : one saturating +1/-1 step on a 3-bit coordinate
package chess_ui_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    COMMIT   = 2'd2
  } ui_state_t;

  localparam int SQ_W = 6;
  localparam logic [2:0] ROW_MAX = 3'd7;
  localparam logic [2:0] COL_MAX = 3'd7;

  localparam int NUM_BTN     = 7;
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_ENTER   = 4;
  localparam int BTN_ESC     = 5;
  localparam int BTN_CONFIRM = 6;

  // Opposing requests in the same cycle cancel; the value never wraps.
  function automatic logic [2:0] sat_step(input logic [2:0] v, input logic inc,
                                          input logic dec, input logic [2:0] max_v);
    logic [2:0] r;
    r = v;
    if (inc && !dec && (v != max_v)) r = v + 3'd1;
    else if (dec && !inc && (v != 3'd0)) r = v - 3'd1;
    return r;
  endfunction

endpackage

// File: rtl/cursor_input_ctrl_if.sv
// Move handoff between the front-panel controller and the move engine.
//  move_valid : high while a committed move waits for the engine
//  move_ack   : engine accepted the move
//  from_sq    : source square {row,col}
//  to_sq      : destination square {row,col}
// Handshake: the controller raises move_valid with from_sq/to_sq stable and holds
// all three unchanged until it samples move_ack=1 on a clock edge; move_valid then
// drops on the following cycle. move_ack while move_valid=0 has no effect.
interface cursor_input_ctrl_if;
  import chess_ui_pkg::*;

  logic            move_valid;
  logic            move_ack;
  logic [SQ_W-1:0] from_sq;
  logic [SQ_W-1:0] to_sq;

  modport master (output move_valid, output from_sq, output to_sq, input move_ack);
  modport slave  (input move_valid, input from_sq, input to_sq, output move_ack);
endinterface

// File: rtl/button_debounce.sv
// Debouncer for one raw active-low push button.
//  clk12       : system clock
//  reset       : asynchronous active-low reset
//  raw_n       : raw button level, asynchronous to clk12, 0 = pressed
//  press_pulse : one-cycle pulse when the debounced level goes released->pressed
// The raw input passes a 2-flop synchroniser. The counter runs while the synced
// level disagrees with the stable level and restarts whenever they agree again, so
// only a level held for DEBOUNCE_CYCLES consecutive synced cycles is accepted.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk12,
  input  logic reset,
  input  logic raw_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync1_d  = raw_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      pulse_d  = ~sync2_q;  // only the transition to pressed (0) is an event
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/cursor_input_ctrl.sv
// Front-panel input stage: debounces seven buttons, moves the board cursor and
// runs the select / cancel / commit state machine feeding the move engine.
//  clk12, reset          : clock and asynchronous active-low reset
//  btn_*_n               : raw active-low buttons (up, down, left, right, enter, esc, confirm)
//  lock                  : engine busy, discards all button events
//  mv (master)           : move_valid / move_ack handshake plus from_sq / to_sq
//  cursor                : {row,col} of the highlighted square
//  enter_pressed         : a source square is selected (SELECTED or COMMIT)
//  esc_pressed           : one-cycle pulse on cancel
//  confirm_pressed       : move committed, awaiting move_ack
//  state_dbg             : current selection state
module cursor_input_ctrl
  import chess_ui_pkg::*;
#(
  parameter int              DEBOUNCE_CYCLES = 120000,
  parameter logic [SQ_W-1:0] CURSOR_RESET    = 6'o00
) (
  input  logic                  clk12,
  input  logic                  reset,
  input  logic                  btn_up_n,
  input  logic                  btn_down_n,
  input  logic                  btn_left_n,
  input  logic                  btn_right_n,
  input  logic                  btn_enter_n,
  input  logic                  btn_esc_n,
  input  logic                  btn_confirm_n,
  input  logic                  lock,
  cursor_input_ctrl_if.master   mv,
  output logic [SQ_W-1:0]       cursor,
  output logic                  enter_pressed,
  output logic                  esc_pressed,
  output logic                  confirm_pressed,
  output ui_state_t             state_dbg
);

  logic [NUM_BTN-1:0] raw_n;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] ev;

  assign raw_n = {btn_confirm_n, btn_esc_n, btn_enter_n, btn_right_n,
                  btn_left_n, btn_down_n, btn_up_n};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk12       (clk12),
      .reset       (reset),
      .raw_n       (raw_n[g]),
      .press_pulse (press[g])
    );
  end

  assign ev = lock ? '0 : press;

  ui_state_t       state_q, state_d;
  logic [SQ_W-1:0] cursor_q, cursor_d;
  logic [SQ_W-1:0] from_q, from_d;
  logic [SQ_W-1:0] to_q, to_d;
  logic            enter_q, enter_d;
  logic            confirm_q, confirm_d;
  logic            esc_q, esc_d;

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    from_d    = from_q;
    to_d      = to_q;
    enter_d   = enter_q;
    confirm_d = confirm_q;
    esc_d     = 1'b0;

    if (state_q != COMMIT) begin
      cursor_d = {sat_step(cursor_q[5:3], ev[BTN_UP], ev[BTN_DOWN], ROW_MAX),
                  sat_step(cursor_q[2:0], ev[BTN_RIGHT], ev[BTN_LEFT], COL_MAX)};
    end

    // Squares are latched from the cursor value before this cycle's move.
    unique case (state_q)
      IDLE: begin
        if (ev[BTN_ENTER]) begin
          state_d = SELECTED;
          from_d  = cursor_q;
          enter_d = 1'b1;
        end
      end
      SELECTED: begin
        if (ev[BTN_ESC]) begin
          state_d = IDLE;
          enter_d = 1'b0;
          esc_d   = 1'b1;
        end else if (ev[BTN_CONFIRM] && (cursor_q != from_q)) begin
          state_d   = COMMIT;
          to_d      = cursor_q;
          confirm_d = 1'b1;
        end else if (ev[BTN_ENTER]) begin
          from_d = cursor_q;
        end
      end
      COMMIT: begin
        if (mv.move_ack) begin
          state_d   = IDLE;
          enter_d   = 1'b0;
          confirm_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        enter_d   = 1'b0;
        confirm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cursor_q  <= CURSOR_RESET;
      from_q    <= '0;
      to_q      <= '0;
      enter_q   <= 1'b0;
      confirm_q <= 1'b0;
      esc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      from_q    <= from_d;
      to_q      <= to_d;
      enter_q   <= enter_d;
      confirm_q <= confirm_d;
      esc_q     <= esc_d;
    end
  end

  assign cursor          = cursor_q;
  assign enter_pressed   = enter_q;
  assign esc_pressed     = esc_q;
  assign confirm_pressed = confirm_q;
  assign state_dbg       = state_q;
  assign mv.move_valid   = confirm_q;
  assign mv.from_sq      = from_q;
  assign mv.to_sq        = to_q;

endmodule

// File: tb/tb_cursor_input_ctrl.sv
module tb_cursor_input_ctrl;
  import chess_ui_pkg::*;

  localparam int DB = 4;

  // ---------------- clock / reset ----------------
  logic clk12 = 1'b0;
  logic reset;
  always #5 clk12 = ~clk12;

  logic [6:0] btn_n;  // bit order follows BTN_* indices
  logic       lock;
  logic [5:0] cursor;
  logic       enter_pressed, esc_pressed, confirm_pressed;
  ui_state_t  state_dbg;

  cursor_input_ctrl_if mv_if ();

  cursor_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CURSOR_RESET(6'o00)) dut (
    .clk12           (clk12),
    .reset           (reset),
    .btn_up_n        (btn_n[BTN_UP]),
    .btn_down_n      (btn_n[BTN_DOWN]),
    .btn_left_n      (btn_n[BTN_LEFT]),
    .btn_right_n     (btn_n[BTN_RIGHT]),
    .btn_enter_n     (btn_n[BTN_ENTER]),
    .btn_esc_n       (btn_n[BTN_ESC]),
    .btn_confirm_n   (btn_n[BTN_CONFIRM]),
    .lock            (lock),
    .mv              (mv_if.master),
    .cursor          (cursor),
    .enter_pressed   (enter_pressed),
    .esc_pressed     (esc_pressed),
    .confirm_pressed (confirm_pressed),
    .state_dbg       (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int        m_row, m_col;
  ui_state_t m_state;
  logic [5:0] m_from, m_to;

  function automatic int clamp7(input int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  function automatic logic [5:0] m_cur();
    return {3'(m_row), 3'(m_col)};
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_state = IDLE; m_from = '0; m_to = '0;
  endtask

  // Apply one debounced event set, using the cursor as it stood before the move.
  task automatic model_apply(input logic [6:0] m, input bit lk);
    logic [5:0] old;
    if (lk) return;
    old = m_cur();
    if (m_state != COMMIT) begin
      m_row = clamp7(m_row + int'(m[BTN_UP]) - int'(m[BTN_DOWN]));
      m_col = clamp7(m_col + int'(m[BTN_RIGHT]) - int'(m[BTN_LEFT]));
    end
    if (m_state == IDLE) begin
      if (m[BTN_ENTER]) begin m_state = SELECTED; m_from = old; end
    end else if (m_state == SELECTED) begin
      if (m[BTN_ESC]) m_state = IDLE;
      else if (m[BTN_CONFIRM] && old != m_from) begin m_state = COMMIT; m_to = old; end
      else if (m[BTN_ENTER]) m_from = old;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".cursor"},  32'(cursor), 32'(m_cur()));
    chk({tag, ".state"},   32'(state_dbg), 32'(m_state));
    chk({tag, ".enter"},   32'(enter_pressed), 32'(m_state != IDLE));
    chk({tag, ".confirm"}, 32'(confirm_pressed), 32'(m_state == COMMIT));
    chk({tag, ".valid"},   32'(mv_if.move_valid), 32'(m_state == COMMIT));
    chk({tag, ".from"},    32'(mv_if.from_sq), 32'(m_from));
    chk({tag, ".to"},      32'(mv_if.to_sq), 32'(m_to));
    chk({tag, ".esc"},     32'(esc_pressed), 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk12);
    #1;
  endtask

  task automatic press(input logic [6:0] m, input bit lk);
    lock  = lk;
    btn_n = ~m;
    tick(DB + 6);
    btn_n = '1;
    tick(DB + 6);
    lock  = 1'b0;
    model_apply(m, lk);
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(7'(1 << b), 1'b0);
  endtask

  task automatic ack_pulse();
    mv_if.move_ack = 1'b1;
    tick(1);
    mv_if.move_ack = 1'b0;
    if (m_state == COMMIT) m_state = IDLE;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; btn_n = '1; lock = 1'b0; mv_if.move_ack = 1'b0;
    model_reset();
    #1;
    chk_all("reset");
    tick(2);
    reset = 1'b1;
    tick(1);

    // Latency: right held 20 cycles, one event, cursor changes on the 7th edge.
    btn_n[BTN_RIGHT] = 1'b0;
    tick(6);
    chk("lat.before", 32'(cursor), 32'(6'o00));
    tick(1);
    chk("lat.after", 32'(cursor), 32'(6'o01));
    tick(13);
    btn_n = '1;
    tick(10);
    m_col = 1;
    chk_all("hold20");

    // Glitch shorter than the debounce window.
    btn_n[BTN_UP] = 1'b0;
    tick(3);
    btn_n = '1;
    tick(12);
    chk_all("glitch");

    // Saturation at row 0 and row 7.
    press_n(BTN_RIGHT, 4);
    chk("to05", 32'(cursor), 32'(6'o05));
    press_n(BTN_DOWN, 1);
    chk("down_sat", 32'(cursor), 32'(6'o05));
    press_n(BTN_UP, 10);
    chk("up_sat", 32'(cursor), 32'(6'o75));
    chk_all("sat");

    // Full move 12 -> 14, held until acknowledged.
    press_n(BTN_DOWN, 6);
    press_n(BTN_LEFT, 3);
    chk("at12", 32'(cursor), 32'(6'o12));
    press_n(BTN_ENTER, 1);
    press_n(BTN_RIGHT, 2);
    press_n(BTN_CONFIRM, 1);
    chk("mv.from", 32'(mv_if.from_sq), 32'(6'o12));
    chk("mv.to", 32'(mv_if.to_sq), 32'(6'o14));
    for (int i = 0; i < 5; i++) begin
      tick(10);
      chk("mv.hold_valid", 32'(mv_if.move_valid), 32'd1);
      chk("mv.hold_conf", 32'(confirm_pressed), 32'd1);
    end
    press_n(BTN_LEFT, 1);  // ignored while committed
    ack_pulse();
    chk_all("acked");

    // esc and confirm together: esc wins, single pulse.
    press_n(BTN_UP, 2);
    press_n(BTN_LEFT, 1);
    chk("at33", 32'(cursor), 32'(6'o33));
    press_n(BTN_ENTER, 1);
    press_n(BTN_RIGHT, 1);
    btn_n[BTN_ESC] = 1'b0;
    btn_n[BTN_CONFIRM] = 1'b0;
    tick(DB + 3);
    chk("esc.pulse", 32'(esc_pressed), 32'd1);
    chk("esc.enter", 32'(enter_pressed), 32'd0);
    chk("esc.valid", 32'(mv_if.move_valid), 32'd0);
    tick(1);
    chk("esc.single", 32'(esc_pressed), 32'd0);
    btn_n = '1;
    tick(10);
    m_state = IDLE;
    chk_all("esc");

    // Lock discards enter; ack outside COMMIT ignored.
    press(7'(1 << BTN_ENTER), 1'b1);
    chk_all("lock");
    ack_pulse();
    chk_all("stray_ack");

    // Randomized walk against the model.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r >= 8) begin
        ack_pulse();
      end else begin
        int b;
        logic [6:0] m;
        b = $urandom_range(0, 6);
        m = 7'(1 << b);
        if ($urandom_range(0, 5) == 0) m[$urandom_range(0, 6)] = 1'b1;
        press(m, $urandom_range(0, 7) == 0);
      end
      chk_all("rand");
    end

    // Reset in the middle of a committed move.
    if (m_state == COMMIT) ack_pulse();
    if (m_state == SELECTED) press_n(BTN_ESC, 1);
    press_n(BTN_ENTER, 1);
    press_n((m_col < 7) ? BTN_RIGHT : BTN_LEFT, 1);
    press_n(BTN_CONFIRM, 1);
    chk("pre_rst.valid", 32'(mv_if.move_valid), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst");
    tick(2);
    reset = 1'b1;
    tick(2);
    chk_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
